// File: rtl/expand_tokens.sv
// ============================================================================
// Module   : expand_tokens
// Function : Serial token expander. Every '1' on a yields FACTOR '1's on b,
//            one per cycle, with the first leaving in the same cycle. Tokens
//            that cannot leave yet wait in a saturating pending counter; a
//            sticky overflow flag records any tokens lost to saturation.
// Options  : EXPAND_TOKENS_CLEAR_EN adds a synchronous clear input (clr)
//            that drops all pending tokens and the overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module expand_tokens #(
  parameter int FACTOR      = 2,
  parameter int MAX_PENDING = 7,
  localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef EXPAND_TOKENS_CLEAR_EN
  input  logic             clr,
`endif
  input  logic             a,
  output logic             b,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  // Wide enough that pending + FACTOR (FACTOR <= 16) can never wrap.
  localparam int TOT_W = CNT_W + 5;

  logic [CNT_W-1:0] pending_q;
  logic [CNT_W-1:0] pending_d;
  logic             overflow_q;
  logic             overflow_d;
  logic [TOT_W-1:0] total;
  logic [TOT_W-1:0] nxt;
  logic             emit;
  logic             clear;

`ifdef EXPAND_TOKENS_CLEAR_EN
  assign clear = clr;
`else
  assign clear = 1'b0;
`endif

  // Token arithmetic: add this cycle's expansion, emit one, saturate the rest.
  always_comb begin
    total      = TOT_W'(pending_q) + (a ? TOT_W'(FACTOR) : '0);
    emit       = (total != '0);
    nxt        = total - TOT_W'(emit);
    pending_d  = nxt[CNT_W-1:0];
    overflow_d = overflow_q;
    if (nxt > TOT_W'(MAX_PENDING)) begin
      pending_d  = CNT_W'(MAX_PENDING);
      overflow_d = 1'b1;
    end
  end

  // Output token is suppressed while reset or clear discards the state.
  assign b        = emit & ~rst & ~clear;
  assign pending  = pending_q;
  assign overflow = overflow_q;

  // State registers; reset wins over clear, clear wins over normal update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_expand_tokens.sv
// ============================================================================
// Module   : tb_expand_tokens
// Function : Self-checking bench for expand_tokens (FACTOR=2 and FACTOR=1
//            instances). Define EXPAND_TOKENS_CLEAR_EN to exercise clr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_expand_tokens;

  localparam int F  = 2;
  localparam int MP = 7;
  localparam int CW = $clog2(MP + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a   = 1'b0;
  logic          clr = 1'b0;
  logic          b, overflow;
  logic [CW-1:0] pending;
  logic          b1, overflow1;
  logic [CW-1:0] pending1;

  always #5 clk = ~clk;

  expand_tokens #(.FACTOR(F), .MAX_PENDING(MP)) u_dut (
    .clk      (clk),
    .rst      (rst),
`ifdef EXPAND_TOKENS_CLEAR_EN
    .clr      (clr),
`endif
    .a        (a),
    .b        (b),
    .pending  (pending),
    .overflow (overflow)
  );

  expand_tokens #(.FACTOR(1), .MAX_PENDING(MP)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
`ifdef EXPAND_TOKENS_CLEAR_EN
    .clr      (clr),
`endif
    .a        (a),
    .b        (b1),
    .pending  (pending1),
    .overflow (overflow1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: tokens owed as a plain integer count.
  int m_pend = 0;
  bit m_ovf  = 1'b0;

  task automatic model_step(input bit ai, input bit ri, input bit ci, output int eb);
    int owed;
    if (ri || ci) begin
      eb     = 0;
      m_pend = 0;
      m_ovf  = 1'b0;
    end else begin
      owed = m_pend + (ai ? F : 0);
      eb   = (owed > 0) ? 1 : 0;
      owed = owed - eb;
      if (owed > MP) begin
        m_pend = MP;
        m_ovf  = 1'b1;
      end else begin
        m_pend = owed;
      end
    end
  endtask

  // Drive one cycle; sample b mid-cycle, return after the edge has settled.
  task automatic cycle(input bit ai, input bit ri, input bit ci, output int b_s, output int b1_s);
    a   = ai;
    rst = ri;
    clr = ci;
    @(negedge clk);
    b_s  = int'(b);
    b1_s = int'(b1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit a;
    bit rst;
    bit eb;
    int ep;
    bit eo;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit ai, input bit ri, input bit eb, input int ep, input bit eo);
    vec_t v;
    v.a = ai; v.rst = ri; v.eb = eb; v.ep = ep; v.eo = eo;
    tbl.push_back(v);
  endtask

  initial begin
    int bs, b1s, eb, na, nb;
    bit ai, ri, ci;

    // ---- directed table ----
    add(0, 1, 0, 0, 0);                                  // reset
    add(1, 0, 1, 1, 0); add(0, 0, 1, 0, 0);              // single token
    add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add(1, 0, 1, i, 0);     // burst of 4
    for (int i = 3; i >= 0; i--) add(0, 0, 1, i, 0);
    add(0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) add(1, 0, 1, i, 0);     // saturation
    add(1, 0, 1, 7, 1);
    for (int i = 6; i >= 0; i--) add(0, 0, 1, i, 1);
    add(0, 0, 0, 0, 1);                                  // sticky after drain
    for (int i = 1; i <= 3; i++) add(1, 0, 1, i, 1);     // pending = 3
    add(1, 1, 0, 0, 0);                                  // reset mid-drain
    add(0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0); add(0, 0, 1, 0, 0);              // b follows a after reset

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      cycle(tbl[i].a, tbl[i].rst, 1'b0, bs, b1s);
      check($sformatf("vec%0d b", i), bs, int'(tbl[i].eb));
      check($sformatf("vec%0d pending", i), int'(pending), tbl[i].ep);
      check($sformatf("vec%0d overflow", i), int'(overflow), int'(tbl[i].eo));
    end

`ifdef EXPAND_TOKENS_CLEAR_EN
    // ---- clear with pending = 5 and overflow set ----
    cycle(0, 1, 0, bs, b1s);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, bs, b1s);
    cycle(0, 0, 0, bs, b1s);
    cycle(0, 0, 0, bs, b1s);
    check("clr setup pending", int'(pending), 5);
    check("clr setup overflow", int'(overflow), 1);
    cycle(1, 0, 1, bs, b1s);
    check("clr b", bs, 0);
    check("clr pending", int'(pending), 0);
    check("clr overflow", int'(overflow), 0);
    cycle(1, 0, 0, bs, b1s);
    check("post-clr b0", bs, 1);
    cycle(0, 0, 0, bs, b1s);
    check("post-clr b1", bs, 1);
    check("post-clr pending", int'(pending), 0);
`endif

    // ---- randomized run against the model; FACTOR=1 must mirror a ----
    cycle(0, 1, 0, bs, b1s);
    model_step(0, 1, 0, eb);
    for (int i = 0; i < 300; i++) begin
      ai = ($urandom_range(0, 99) < 55);
      ri = ($urandom_range(0, 59) == 0);
`ifdef EXPAND_TOKENS_CLEAR_EN
      ci = ($urandom_range(0, 39) == 0);
`else
      ci = 1'b0;
`endif
      cycle(ai, ri, ci, bs, b1s);
      model_step(ai, ri, ci, eb);
      check($sformatf("rnd%0d b", i), bs, eb);
      check($sformatf("rnd%0d pending", i), int'(pending), m_pend);
      check($sformatf("rnd%0d overflow", i), int'(overflow), int'(m_ovf));
      check($sformatf("rnd%0d f1 b", i), b1s, (ri || ci) ? 0 : int'(ai));
      check($sformatf("rnd%0d f1 pending", i), int'(pending1), 0);
      check($sformatf("rnd%0d f1 overflow", i), int'(overflow1), 0);
    end

    // ---- token conservation on a sparse stream ----
    cycle(0, 1, 0, bs, b1s);
    model_step(0, 1, 0, eb);
    na = 0;
    nb = 0;
    for (int i = 0; i < 60; i++) begin
      ai = ($urandom_range(0, 99) < 35);
      cycle(ai, 0, 0, bs, b1s);
      model_step(ai, 0, 0, eb);
      na += int'(ai);
      nb += bs;
    end
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0, bs, b1s);
      model_step(0, 0, 0, eb);
      nb += bs;
    end
    check("drain pending", int'(pending), 0);
    check("conserve overflow", int'(overflow), int'(m_ovf));
    if (!m_ovf) check("conserve count", nb, F * na);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
